// File: rtl/vsbc_seq.sv
// Multi-channel handshaked variable-shift bitstream counter: counts ones on NCH
// Z streams per job and left-shifts each count by popcount of the masked S groups.
module vsbc_seq #(
    parameter int unsigned W        = 4,
    parameter int unsigned S_GROUPS = 2,
    parameter int unsigned TW       = 8,
    parameter int unsigned NC       = 1,
    parameter int unsigned NCH      = 4,
    parameter int unsigned LEN_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W*S_GROUPS-1:0]   s_in,
    input  logic [W-1:0]            ell,
    input  logic [LEN_W-1:0]        len,
    input  logic                    et_en,
    input  logic [TW-1:0]           et_thresh,
    input  logic                    z_valid,
    output logic                    z_ready,
    input  logic [NCH-1:0]          z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NCH*TW-1:0]       bz,
    output logic [NCH-1:0]          ovf,
    output logic                    et_hit,
    output logic [LEN_W-1:0]        beats
);

    localparam int unsigned AW = $clog2(TW + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                     state_q, state_d;
    logic [TW-1:0]              s_q, s_d;
    logic [W-1:0]               ell_q, ell_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic                       et_en_q, et_en_d;
    logic [TW-1:0]              thr_q, thr_d;
    logic [AW-1:0]              apc_q, apc_d;
    logic [NCH-1:0][TW-1:0]     cnt_q, cnt_d;
    logic [LEN_W-1:0]           beats_q, beats_d;
    logic [NCH-1:0][TW-1:0]     bz_q, bz_d;
    logic [NCH-1:0]             ovf_q, ovf_d;
    logic                       et_hit_q, et_hit_d;
    logic                       in_ready_q, in_ready_d;
    logic                       z_ready_q, z_ready_d;
    logic                       out_valid_q, out_valid_d;

    logic [TW-1:0]              s_flat;
    logic [AW-1:0]              apc_calc;
    logic [LEN_W-1:0]           beats_inc;
    logic                       all_ge;
    logic                       last_beat;
    logic [2*TW-1:0]            wide;

    // Effective shift amount from the latched S groups and low-group mask
    always_comb begin
        s_flat = s_q;
        for (int unsigned i = TW - NC; i < TW; i++) begin
            s_flat[i] = 1'b0;
        end
        s_flat[W-1:0] = s_flat[W-1:0] & ~ell_q;
        apc_calc = '0;
        for (int unsigned i = 0; i < TW; i++) begin
            apc_calc = apc_calc + AW'(s_flat[i]);
        end
    end

    assign beats_inc = beats_q + LEN_W'(1);

    // Next-state, datapath and Moore handshake outputs
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        ell_d       = ell_q;
        len_d       = len_q;
        et_en_d     = et_en_q;
        thr_d       = thr_q;
        apc_d       = apc_q;
        cnt_d       = cnt_q;
        beats_d     = beats_q;
        bz_d        = bz_q;
        ovf_d       = ovf_q;
        et_hit_d    = et_hit_q;
        all_ge      = 1'b1;
        last_beat   = 1'b0;
        wide        = '0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d      = TW'(s_in);
                    ell_d    = ell;
                    len_d    = len;
                    et_en_d  = et_en;
                    thr_d    = et_thresh;
                    cnt_d    = '0;
                    beats_d  = '0;
                    et_hit_d = 1'b0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                apc_d   = apc_calc;
                state_d = (len_q == '0) ? DONE : RUN;
            end
            RUN: begin
                if (z_valid && z_ready_q) begin
                    for (int unsigned c = 0; c < NCH; c++) begin
                        if (z[c] && (cnt_q[c] != '1)) begin
                            cnt_d[c] = cnt_q[c] + TW'(1);
                        end
                        if (cnt_d[c] < thr_q) begin
                            all_ge = 1'b0;
                        end
                    end
                    beats_d   = beats_inc;
                    last_beat = (beats_inc == len_q);
                    if (et_en_q && all_ge) begin
                        et_hit_d = 1'b1;
                    end
                    if (last_beat || (et_en_q && all_ge)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Result is captured once, on the transition into DONE
        if ((state_d == DONE) && (state_q != DONE)) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                wide     = {TW'(0), cnt_d[c]} << apc_d;
                bz_d[c]  = wide[TW-1:0];
                ovf_d[c] = |wide[2*TW-1:TW];
            end
        end

        in_ready_d  = (state_d == IDLE);
        z_ready_d   = (state_d == RUN);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            ell_q       <= '0;
            len_q       <= '0;
            et_en_q     <= 1'b0;
            thr_q       <= '0;
            apc_q       <= '0;
            cnt_q       <= '0;
            beats_q     <= '0;
            bz_q        <= '0;
            ovf_q       <= '0;
            et_hit_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            z_ready_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            ell_q       <= ell_d;
            len_q       <= len_d;
            et_en_q     <= et_en_d;
            thr_q       <= thr_d;
            apc_q       <= apc_d;
            cnt_q       <= cnt_d;
            beats_q     <= beats_d;
            bz_q        <= bz_d;
            ovf_q       <= ovf_d;
            et_hit_q    <= et_hit_d;
            in_ready_q  <= in_ready_d;
            z_ready_q   <= z_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign z_ready   = z_ready_q;
    assign out_valid = out_valid_q;
    assign bz        = bz_q;
    assign ovf       = ovf_q;
    assign et_hit    = et_hit_q;
    assign beats     = beats_q;

endmodule

// File: tb/tb_vsbc_seq.sv
// Directed self-checking bench for vsbc_seq with hand-computed expected results.
module tb_vsbc_seq;

    localparam int unsigned W     = 4;
    localparam int unsigned SG    = 2;
    localparam int unsigned TW    = 8;
    localparam int unsigned NCH   = 4;
    localparam int unsigned LEN_W = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [W*SG-1:0]      s_in;
    logic [W-1:0]         ell;
    logic [LEN_W-1:0]     len;
    logic                 et_en;
    logic [TW-1:0]        et_thresh;
    logic                 z_valid;
    logic                 z_ready;
    logic [NCH-1:0]       z;
    logic                 out_valid;
    logic                 out_ready;
    logic [NCH*TW-1:0]    bz;
    logic [NCH-1:0]       ovf;
    logic                 et_hit;
    logic [LEN_W-1:0]     beats;

    logic [NCH-1:0]       z_pat [0:63];
    int                   n_cmp = 0;
    int                   n_err = 0;
    bit                   saw_zr;

    vsbc_seq #(.W(W), .S_GROUPS(SG), .TW(TW), .NC(1), .NCH(NCH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s_in      (s_in),
        .ell       (ell),
        .len       (len),
        .et_en     (et_en),
        .et_thresh (et_thresh),
        .z_valid   (z_valid),
        .z_ready   (z_ready),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bz        (bz),
        .ovf       (ovf),
        .et_hit    (et_hit),
        .beats     (beats)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_job(input logic [7:0] s, input logic [3:0] e, input logic [7:0] l,
                            input logic ete, input logic [7:0] thr);
        s_in = s; ell = e; len = l; et_en = ete; et_thresh = thr;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        s_in = '1; ell = '1; len = '1; et_en = 1'b1; et_thresh = '0;
    endtask

    // Drive z_pat beats until out_valid, nmax transfers, or the cycle budget runs out
    task automatic feed(input int nmax, input bit toggle);
        int idx = 0;
        int cyc = 0;
        bit ph = 1'b1;
        saw_zr = 1'b0;
        while (!out_valid && idx < nmax && cyc < 300) begin
            if (z_ready) saw_zr = 1'b1;
            z_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            z = z_pat[idx];
            if (z_valid && z_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        z_valid = 1'b0;
        z = '0;
        if (cyc >= 300) check("feed_timeout", 64'(cyc), 64'(0));
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("rel_out_valid", 64'(out_valid), 64'(0));
        check("rel_in_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; s_in = '0; ell = '0; len = '0; et_en = 1'b0;
        et_thresh = '0; z_valid = 1'b0; z = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_z_ready", 64'(z_ready), 64'(0));
        check("rst_bz", 64'(bz), 64'(0));
        check("rst_flags", 64'({ovf, et_hit, beats}), 64'(0));

        // Basic job: shift by 1, five all-ones beats
        for (int i = 0; i < 64; i++) z_pat[i] = 4'hF;
        send_job(8'b0000_0011, 4'b0001, 8'd5, 1'b0, 8'd0);
        feed(64, 1'b0);
        check("t1_out_valid", 64'(out_valid), 64'(1));
        check("t1_bz", 64'(bz), 64'h0A0A0A0A);
        check("t1_ovf", 64'(ovf), 64'(0));
        check("t1_beats", 64'(beats), 64'(5));
        check("t1_et_hit", 64'(et_hit), 64'(0));
        release_out();

        // Zero-length job
        send_job(8'hFF, 4'h0, 8'd0, 1'b0, 8'd0);
        feed(64, 1'b0);
        check("t2_out_valid", 64'(out_valid), 64'(1));
        check("t2_bz", 64'(bz), 64'(0));
        check("t2_beats", 64'(beats), 64'(0));
        check("t2_no_zready", 64'(saw_zr), 64'(0));
        release_out();

        // Shift overflow: 40 << 3
        send_job(8'b0111_0000, 4'h0, 8'd40, 1'b0, 8'd0);
        feed(64, 1'b0);
        check("t3_bz", 64'(bz), 64'h40404040);
        check("t3_ovf", 64'(ovf), 64'hF);
        check("t3_beats", 64'(beats), 64'(40));
        release_out();

        // Early termination when ch3 reaches 3 on beat 9
        for (int i = 0; i < 64; i++)
            z_pat[i] = {((i == 0) || (i == 5) || (i == 9)), 3'b111};
        send_job(8'h01, 4'h0, 8'd20, 1'b1, 8'd3);
        feed(64, 1'b0);
        check("t4_bz", 64'(bz), 64'h06141414);
        check("t4_beats", 64'(beats), 64'(10));
        check("t4_et_hit", 64'(et_hit), 64'(1));
        check("t4_ovf", 64'(ovf), 64'(0));
        release_out();

        // Stalled Z plus held back-pressure on the result
        for (int i = 0; i < 64; i++) z_pat[i] = 4'hF;
        send_job(8'b0000_0011, 4'b0001, 8'd5, 1'b0, 8'd0);
        feed(64, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("t5_hold_valid", 64'(out_valid), 64'(1));
            check("t5_hold_bz", 64'(bz), 64'h0A0A0A0A);
            check("t5_hold_beats", 64'(beats), 64'(5));
            @(negedge clk);
        end
        release_out();

        // Reset mid-run, then a fresh short job
        send_job(8'h00, 4'h0, 8'd10, 1'b0, 8'd0);
        feed(3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_in_ready", 64'(in_ready), 64'(1));
        check("t6_rst_z_ready", 64'(z_ready), 64'(0));
        check("t6_rst_out_valid", 64'(out_valid), 64'(0));
        check("t6_rst_bz", 64'(bz), 64'(0));
        check("t6_rst_beats", 64'(beats), 64'(0));
        z_pat[0] = 4'b1010;
        z_pat[1] = 4'b0000;
        send_job(8'h00, 4'h0, 8'd2, 1'b0, 8'd0);
        feed(64, 1'b0);
        check("t6_bz", 64'(bz), 64'h01000100);
        check("t6_beats", 64'(beats), 64'(2));
        release_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
